// File: rtl/subtrator_serial_4bits_if.sv
// Start/done handshake bundle between the controller and the bit-serial subtractor.
// The controller drives the operands and start; the subtractor returns status and result.
interface subtrator_serial_4bits_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/subtrator_serial_4bits.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
// The result and final borrow are held until the next operation completes.
module subtrator_serial_4bits #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  subtrator_serial_4bits_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               brw_q, brw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;

  logic               d_bit;
  logic               brw_next;
  logic               last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // One full-subtractor stage on the current LSBs plus the carried borrow.
  assign d_bit    = sa_q[0] ^ sb_q[0] ^ brw_q;
  assign brw_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d  = bus.a;
          sb_d  = bus.b;
          res_d = '0;
          brw_d = 1'b0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        // Result bits enter at the MSB so the first (LSB) bit ends at bit 0.
        res_d = {d_bit, res_q[WIDTH-1:1]};
        brw_d = brw_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = brw_next;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q == SHIFT);
    bus.done       = (state_q == DONE);
    bus.diff       = diff_q;
    bus.borrow_out = borrow_q;
  end

endmodule

// File: tb/tb_subtrator_serial_4bits.sv
// Directed self-checking bench for the bit-serial subtractor.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_subtrator_serial_4bits;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  subtrator_serial_4bits_if #(.WIDTH(4)) sub_if ();

  subtrator_serial_4bits #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation and reports what was seen on its done pulse.
  task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                       output logic [3:0] d, output logic bo,
                       output int busy_n, output int lat, output bit to);
    to = 1'b1; busy_n = 0; lat = 0; d = '0; bo = 1'b0;
    @(negedge clk);
    sub_if.a = av; sub_if.b = bv; sub_if.start = 1'b1;
    @(negedge clk);
    sub_if.start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (sub_if.done) begin
        d = sub_if.diff; bo = sub_if.borrow_out; lat = i; to = 1'b0;
        break;
      end
      if (sub_if.busy) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sub_if.start = 1'b0; sub_if.a = '0; sub_if.b = '0;
    #12;
    checks++;
    if (sub_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", sub_if.busy); end
    checks++;
    if (sub_if.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", sub_if.done); end
    checks++;
    if (sub_if.diff !== 4'd0) begin errors++; $display("[TB] FAIL reset_diff: got %0d expected 0", sub_if.diff); end
    checks++;
    if (sub_if.borrow_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow: got %b expected 0", sub_if.borrow_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] d; logic bo; int bn, lat; bit to;
    do_op(4'd6, 4'd3, d, bo, bn, lat, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (bn !== 4) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 4", bn); end
    checks++;
    if (lat !== 5) begin errors++; $display("[TB] FAIL basic_done_latency: got %0d expected 5", lat); end
    checks++;
    if (d !== 4'd3) begin errors++; $display("[TB] FAIL basic_diff: got %0d expected 3", d); end
    checks++;
    if (bo !== 1'b0) begin errors++; $display("[TB] FAIL basic_borrow: got %b expected 0", bo); end
    @(negedge clk);
    checks++;
    if (sub_if.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width: got %b expected 0", sub_if.done); end
  endtask

  task automatic test_vectors();
    logic [3:0] va [6] = '{4'd3, 4'd0, 4'd15, 4'd0, 4'd15, 4'd8};
    logic [3:0] vb [6] = '{4'd6, 4'd1, 4'd15, 4'd0, 4'd0,  4'd15};
    logic [3:0] ed [6] = '{4'd13, 4'd15, 4'd0, 4'd0, 4'd15, 4'd9};
    logic       eb [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] d; logic bo; int bn, lat; bit to;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], d, bo, bn, lat, to);
      checks++;
      if (to || d !== ed[i]) begin errors++; $display("[TB] FAIL vec_diff %0d-%0d: got %0d expected %0d", va[i], vb[i], d, ed[i]); end
      checks++;
      if (to || bo !== eb[i]) begin errors++; $display("[TB] FAIL vec_borrow %0d-%0d: got %b expected %b", va[i], vb[i], bo, eb[i]); end
    end
  endtask

  task automatic test_ignored_start();
    int lat; bit seen;
    seen = 1'b0; lat = 0;
    @(negedge clk);
    sub_if.a = 4'd6; sub_if.b = 4'd3; sub_if.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      sub_if.a = 4'd1; sub_if.b = 4'd1; sub_if.start = 1'b1;
      if (sub_if.done) begin
        seen = 1'b1; lat = i;
        checks++;
        if (sub_if.diff !== 4'd3) begin errors++; $display("[TB] FAIL ignore_diff: got %0d expected 3", sub_if.diff); end
        break;
      end
    end
    checks++;
    if (!seen || lat !== 5) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 5", lat); end
    // start stays high across the DONE->IDLE edge, then drops before IDLE samples it
    @(negedge clk);
    sub_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sub_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_restart: got %b expected 0", sub_if.busy); end
    checks++;
    if (sub_if.diff !== 4'd3) begin errors++; $display("[TB] FAIL ignore_diff_held: got %0d expected 3", sub_if.diff); end
  endtask

  task automatic test_back_to_back();
    int first_i, second_i;
    first_i = -1; second_i = -1;
    @(negedge clk);
    sub_if.a = 4'd5; sub_if.b = 4'd2; sub_if.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sub_if.done) begin
        if (first_i < 0) begin
          first_i = i;
          checks++;
          if (sub_if.diff !== 4'd3) begin errors++; $display("[TB] FAIL b2b_first_diff: got %0d expected 3", sub_if.diff); end
          sub_if.a = 4'd9; sub_if.b = 4'd4;
        end else begin
          second_i = i;
          checks++;
          if (sub_if.diff !== 4'd5) begin errors++; $display("[TB] FAIL b2b_second_diff: got %0d expected 5", sub_if.diff); end
          break;
        end
      end else if (first_i >= 0) begin
        checks++;
        if (sub_if.diff !== 4'd3) begin errors++; $display("[TB] FAIL b2b_diff_stable: got %0d expected 3", sub_if.diff); end
      end
    end
    sub_if.start = 1'b0;
    checks++;
    if (first_i < 0 || second_i < 0 || (second_i - first_i) !== 6) begin
      errors++; $display("[TB] FAIL b2b_period: got %0d expected 6", second_i - first_i);
    end
  endtask

  task automatic test_reset_midop();
    logic [3:0] d; logic bo; int bn, lat, dones; bit to;
    dones = 0;
    @(negedge clk);
    sub_if.a = 4'd9; sub_if.b = 4'd2; sub_if.start = 1'b1;
    @(negedge clk);
    sub_if.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sub_if.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", sub_if.busy); end
    checks++;
    if (sub_if.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", sub_if.done); end
    checks++;
    if (sub_if.diff !== 4'd0) begin errors++; $display("[TB] FAIL midrst_diff: got %0d expected 0", sub_if.diff); end
    checks++;
    if (sub_if.borrow_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_borrow: got %b expected 0", sub_if.borrow_out); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sub_if.done || sub_if.busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", dones); end
    do_op(4'd9, 4'd2, d, bo, bn, lat, to);
    checks++;
    if (to || d !== 4'd7) begin errors++; $display("[TB] FAIL midrst_after_diff: got %0d expected 7", d); end
    checks++;
    if (to || bo !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after_borrow: got %b expected 0", bo); end
  endtask

  task automatic test_exhaustive();
    logic [3:0] d, ea, eb_v, exp_d; logic bo, exp_b; int bn, lat; bit to;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        ea = 4'(ia); eb_v = 4'(ib);
        exp_d = 4'((ia - ib) & 15);
        exp_b = (ia < ib);
        do_op(ea, eb_v, d, bo, bn, lat, to);
        checks++;
        if (to || d !== exp_d) begin errors++; $display("[TB] FAIL exh_diff %0d-%0d: got %0d expected %0d", ia, ib, d, exp_d); end
        checks++;
        if (to || bo !== exp_b) begin errors++; $display("[TB] FAIL exh_borrow %0d-%0d: got %b expected %b", ia, ib, bo, exp_b); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignored_start();
    test_back_to_back();
    test_reset_midop();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
